// File: rtl/l1i_cache_pkg.sv
// Shared geometry, derived address-field widths and FSM encoding for the L1 I-cache.
package cache_pkg;
  localparam int CACHE_LINE_WIDTH = 64;  // bytes per line
  localparam int L1I_SETS         = 64;  // direct-mapped sets
  localparam int OFF_W            = $clog2(CACHE_LINE_WIDTH);
  localparam int IDX_W            = $clog2(L1I_SETS);
  localparam int TAG_W            = 64 - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} l1i_state_e;

  // Clear the byte-offset bits of an address.
  function automatic logic [63:0] line_align(input logic [63:0] a, input int ow);
    return (a >> ow) << ow;
  endfunction
endpackage

// File: rtl/l1i_cache_if.sv
// Fetch, flush and refill signals between the front end / memory side and the I-cache.
interface l1i_cache_if #(parameter int LINE_BYTES = cache_pkg::CACHE_LINE_WIDTH);
  logic                    bp_valid_in;
  logic [63:0]             bp_addr_in;
  logic                    l1i_ready_out;
  logic                    l1i_valid_out;
  logic [LINE_BYTES*8-1:0] l1i_cacheline_out;
  logic [63:0]             l1i_line_addr_out;
  logic                    flush_in;
  logic                    mem_req_valid_out;
  logic                    mem_req_ready_in;
  logic [63:0]             mem_req_addr_out;
  logic                    mem_resp_valid_in;
  logic [LINE_BYTES*8-1:0] mem_resp_data_in;

  // Front end plus memory model side.
  modport master (
    output bp_valid_in, bp_addr_in, flush_in, mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    input  l1i_ready_out, l1i_valid_out, l1i_cacheline_out, l1i_line_addr_out,
           mem_req_valid_out, mem_req_addr_out
  );

  // Cache side.
  modport slave (
    input  bp_valid_in, bp_addr_in, flush_in, mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    output l1i_ready_out, l1i_valid_out, l1i_cacheline_out, l1i_line_addr_out,
           mem_req_valid_out, mem_req_addr_out
  );
endinterface

// File: rtl/l1i_cache_line_store.sv
// Direct-mapped tag/valid/data array: combinational read, single write port.
// Only the valid bits are reset; tag/data contents are don't-care until valid.
module l1i_line_store
  import cache_pkg::*;
#(
  parameter int  SETS = L1I_SETS,
  parameter int  TW   = TAG_W,
  parameter int  LW   = CACHE_LINE_WIDTH * 8,
  localparam int IW   = $clog2(SETS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [LW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [TW-1:0] wr_tag_i,
  input  logic [LW-1:0] wr_data_i
);
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [LW-1:0]   data_q [SETS];

  // Valid bits: cleared asynchronously, set on fill.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     valid_q <= '0;
    else if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
  end

  // Tag and data storage, overwritten by the fill regardless of the occupant.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/l1i_cache.sv
// Blocking direct-mapped L1 instruction cache: one fetch in flight, 2-cycle hit,
// single-line refill from memory, flush squashes the in-flight fetch.
module l1i_cache
  import cache_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH = cache_pkg::CACHE_LINE_WIDTH,
  parameter int L1I_SETS         = cache_pkg::L1I_SETS
) (
  input logic         clk_in,
  input logic         rst_N_in,
  l1i_cache_if.slave  bus
);
  localparam int OW = $clog2(CACHE_LINE_WIDTH);
  localparam int IW = $clog2(L1I_SETS);
  localparam int TW = 64 - OW - IW;
  localparam int LW = CACHE_LINE_WIDTH * 8;

  l1i_state_e    state_q, state_d;
  logic [63:0]   addr_q, addr_d;     // line-aligned address of the in-flight fetch
  logic          drop_q, drop_d;     // fill continues but its response is squashed
  logic [LW-1:0] line_q, line_d;
  logic [63:0]   laddr_q, laddr_d;
  logic          mreq_v_q, mreq_v_d;
  logic [63:0]   mreq_a_q, mreq_a_d;

  logic          rd_valid, wr_en, hit, ready, accept;
  logic [TW-1:0] rd_tag;
  logic [LW-1:0] rd_data;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;

  assign idx    = addr_q[OW +: IW];
  assign tag    = addr_q[63 -: TW];
  assign hit    = rd_valid && (rd_tag == tag);
  assign ready  = (state_q == IDLE) || (state_q == RESP);
  assign accept = bus.bp_valid_in && ready;

  l1i_line_store #(.SETS(L1I_SETS), .TW(TW), .LW(LW)) u_store (
    .clk_i      (clk_in),
    .rst_n_i    (rst_N_in),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (bus.mem_resp_data_in)
  );

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      drop_q   <= 1'b0;
      line_q   <= '0;
      laddr_q  <= '0;
      mreq_v_q <= 1'b0;
      mreq_a_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      drop_q   <= drop_d;
      line_q   <= line_d;
      laddr_q  <= laddr_d;
      mreq_v_q <= mreq_v_d;
      mreq_a_q <= mreq_a_d;
    end
  end

  // Next-state: lookup, refill handshake, squash handling.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    drop_d   = drop_q;
    line_d   = line_q;
    laddr_d  = laddr_q;
    mreq_v_d = mreq_v_q;
    mreq_a_d = mreq_a_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        // A flush here only hits older work; a new request is still taken.
        if (accept) begin
          addr_d  = line_align(bus.bp_addr_in, OW);
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (bus.flush_in) begin
          state_d = IDLE;
        end else if (hit) begin
          line_d  = rd_data;
          laddr_d = addr_q;
          state_d = RESP;
        end else begin
          mreq_v_d = 1'b1;
          mreq_a_d = addr_q;
          state_d  = MISS_REQ;
        end
      end
      MISS_REQ: begin
        // Request stays up and stable even if squashed, so the fill still completes.
        if (bus.flush_in) drop_d = 1'b1;
        if (bus.mem_req_ready_in) begin
          mreq_v_d = 1'b0;
          state_d  = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (bus.flush_in) drop_d = 1'b1;
        if (bus.mem_resp_valid_in) begin
          wr_en = 1'b1;
          if (drop_q || bus.flush_in) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            line_d  = bus.mem_resp_data_in;
            laddr_d = addr_q;
            state_d = RESP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.l1i_ready_out     = ready;
  assign bus.l1i_valid_out     = (state_q == RESP) && !drop_q && !bus.flush_in;
  assign bus.l1i_cacheline_out = line_q;
  assign bus.l1i_line_addr_out = laddr_q;
  assign bus.mem_req_valid_out = mreq_v_q;
  assign bus.mem_req_addr_out  = mreq_a_q;
endmodule

// File: tb/tb_l1i_cache.sv
// Randomized + directed bench for l1i_cache against a set-level tag/valid model.
module tb_l1i_cache;
  import cache_pkg::*;
  localparam int LB = CACHE_LINE_WIDTH;
  localparam int LW = LB * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  l1i_cache_if bus ();
  l1i_cache dut (.clk_in(clk), .rst_N_in(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  // Model: which line each set holds. Memory content is a fixed function of address.
  bit               mv [L1I_SETS];
  logic [TAG_W-1:0] mt [L1I_SETS];
  logic [LW-1:0]    last_line;
  logic [63:0]      last_la;
  bit               r;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [LW-1:0] memline(input logic [63:0] la);
    logic [LW-1:0] v;
    logic [7:0]    s;
    s = 8'(((la >> OFF_W) - 64'd64) * 64'd37);  // 0x1000 -> ramp 0x00..0x3F
    for (int i = 0; i < LB; i++) v[i*8 +: 8] = 8'(i) + s;
    return v;
  endfunction

  function automatic logic [63:0] rnd_addr();
    return (64'($urandom_range(0, 1)) << 40) | (64'($urandom_range(0, 3)) << 12) |
           (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
  endfunction

  task automatic issue(input logic [63:0] a, input bit fl);
    @(negedge clk);
    bus.bp_valid_in = 1'b1; bus.bp_addr_in = a; bus.flush_in = fl;
    #1 chk("issue_rdy", bus.l1i_ready_out, 1);
    @(posedge clk);
  endtask

  // Call right after a response was seen (still in the RESP cycle).
  task automatic chain(input logic [63:0] a, input bit fl);
    bus.bp_valid_in = 1'b1; bus.bp_addr_in = a; bus.flush_in = fl;
    #1;
    if (fl) chk("resp_flush_masked", bus.l1i_valid_out, 0);
    chk("resp_rdy", bus.l1i_ready_out, 1);
    @(posedge clk);
  endtask

  // fm: 0 none, 1 flush in LOOKUP, 2 flush in MISS_REQ, 3 flush in MISS_WAIT.
  // d: cycles of mem_req backpressure; lat: cycles in MISS_WAIT before data.
  task automatic serve(input logic [63:0] a, input int fm, input int d, input int lat, output bit resp);
    logic [63:0]   la;
    int            ix;
    bit            hit;
    logic [LW-1:0] ml;
    la  = line_align(a, OFF_W);
    ix  = int'(a[OFF_W +: IDX_W]);
    hit = mv[ix] && (mt[ix] == a[63 -: TAG_W]);
    ml  = memline(la);
    resp = 1'b0;
    @(negedge clk);
    bus.bp_valid_in = 1'b0; bus.flush_in = (fm == 1);
    #1 chk("lookup_vld", bus.l1i_valid_out, 0);
    chk("lookup_mreq", bus.mem_req_valid_out, 0);
    chk("lookup_rdy", bus.l1i_ready_out, 0);
    if (fm == 1) begin
      @(negedge clk); bus.flush_in = 1'b0;
      #1 chk("lkflush_vld", bus.l1i_valid_out, 0);
      chk("lkflush_rdy", bus.l1i_ready_out, 1);
      chk("lkflush_mreq", bus.mem_req_valid_out, 0);
      chk("hold_line", bus.l1i_cacheline_out, last_line);
      return;
    end
    if (hit) begin
      @(negedge clk);
      #1 chk("hit_vld", bus.l1i_valid_out, 1);
      chk("hit_line", bus.l1i_cacheline_out, ml);
      chk("hit_la", bus.l1i_line_addr_out, la);
      chk("hit_mreq", bus.mem_req_valid_out, 0);
      last_line = ml; last_la = la; resp = 1'b1;
      return;
    end
    @(negedge clk);
    #1 chk("mreq_vld", bus.mem_req_valid_out, 1);
    chk("mreq_addr", bus.mem_req_addr_out, la);
    if (fm == 2) bus.flush_in = 1'b1;
    repeat (d) begin
      @(negedge clk); bus.flush_in = 1'b0;
      #1 chk("bp_mreq_vld", bus.mem_req_valid_out, 1);
      chk("bp_mreq_addr", bus.mem_req_addr_out, la);
    end
    bus.mem_req_ready_in = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_in = 1'b0; bus.flush_in = (fm == 3);
    #1 chk("wait_mreq", bus.mem_req_valid_out, 0);
    chk("wait_vld", bus.l1i_valid_out, 0);
    repeat (lat) begin
      @(negedge clk); bus.flush_in = 1'b0;
      #1 chk("wait_vld2", bus.l1i_valid_out, 0);
      chk("wait_rdy", bus.l1i_ready_out, 0);
    end
    bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = ml;
    @(negedge clk);
    bus.mem_resp_valid_in = 1'b0; bus.mem_resp_data_in = '0; bus.flush_in = 1'b0;
    mv[ix] = 1'b1; mt[ix] = a[63 -: TAG_W];
    #1;
    if (fm >= 2) begin
      chk("drop_vld", bus.l1i_valid_out, 0);
      chk("drop_rdy", bus.l1i_ready_out, 1);
      chk("hold_line", bus.l1i_cacheline_out, last_line);
      chk("hold_la", bus.l1i_line_addr_out, last_la);
    end else begin
      chk("miss_vld", bus.l1i_valid_out, 1);
      chk("miss_line", bus.l1i_cacheline_out, ml);
      chk("miss_la", bus.l1i_line_addr_out, la);
      last_line = ml; last_la = la; resp = 1'b1;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_vld"}, bus.l1i_valid_out, 0);
    chk({tag, "_line"}, bus.l1i_cacheline_out, 0);
    chk({tag, "_la"}, bus.l1i_line_addr_out, 0);
    chk({tag, "_mreq"}, bus.mem_req_valid_out, 0);
    chk({tag, "_maddr"}, bus.mem_req_addr_out, 0);
  endtask

  initial begin
    logic [63:0] a;
    int fm;
    bus.bp_valid_in = 1'b0; bus.bp_addr_in = '0; bus.flush_in = 1'b0;
    bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = 1'b0; bus.mem_resp_data_in = '0;
    for (int i = 0; i < L1I_SETS; i++) begin mv[i] = 1'b0; mt[i] = '0; end
    last_line = '0; last_la = '0; r = 1'b0;

    #1 rst_n = 1'b0;
    #2 chk_reset_outs("rst");
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_rdy", bus.l1i_ready_out, 1);

    // Cold miss, memory answers after 3 cycles.
    issue(64'h1008, 0); serve(64'h1008, 0, 0, 3, r);
    chk("cold_byte8", bus.l1i_cacheline_out[71:64], 8'h08);
    // Hit, then back-to-back hit straight from RESP.
    issue(64'h1030, 0); serve(64'h1030, 0, 0, 0, r);
    chain(64'h1010, 0);  serve(64'h1010, 0, 0, 0, r);
    // Conflict on set 0.
    issue(64'h2000, 0); serve(64'h2000, 0, 1, 2, r);
    issue(64'h1000, 0); serve(64'h1000, 0, 0, 1, r);
    issue(64'h2000, 0); serve(64'h2000, 0, 0, 0, r);
    // Flush in MISS_WAIT still installs the line.
    issue(64'h1000, 0); serve(64'h1000, 3, 0, 2, r);
    issue(64'h1000, 0); serve(64'h1000, 0, 0, 0, r);
    // Backpressure 5 cycles.
    issue(64'h3000, 0); serve(64'h3000, 0, 5, 2, r);
    // Flush in LOOKUP: no install, so it misses again.
    issue(64'h1040, 0); serve(64'h1040, 1, 0, 0, r);
    issue(64'h1040, 0); serve(64'h1040, 0, 0, 1, r);
    // Flush in MISS_REQ under backpressure.
    issue(64'h1080, 0); serve(64'h1080, 2, 3, 1, r);
    // Flush with new request in IDLE, and in RESP.
    issue(64'h3000, 1); serve(64'h3000, 0, 0, 0, r);
    chain(64'h3010, 1);  serve(64'h3010, 0, 0, 0, r);

    for (int k = 0; k < 120; k++) begin
      a  = rnd_addr();
      fm = $urandom_range(0, 9);
      if (fm > 3) fm = 0;
      if (r && $urandom_range(0, 1) == 1) chain(a, $urandom_range(0, 3) == 0);
      else                                issue(a, $urandom_range(0, 5) == 0);
      serve(a, fm, $urandom_range(0, 3), $urandom_range(0, 3), r);
    end

    // Reset in MISS_WAIT, then a stray late response.
    issue(64'h5040, 0);
    @(negedge clk); bus.bp_valid_in = 1'b0; bus.flush_in = 1'b0;
    @(negedge clk);
    #1 chk("rm_mreq", bus.mem_req_valid_out, 1);
    bus.mem_req_ready_in = 1'b1;
    @(negedge clk); bus.mem_req_ready_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rmid");
    @(negedge clk);
    rst_n = 1'b1; bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = memline(64'h5040);
    #1 chk("stray_vld", bus.l1i_valid_out, 0);
    @(negedge clk); bus.mem_resp_valid_in = 1'b0; bus.mem_resp_data_in = '0;
    #1 chk("stray_vld2", bus.l1i_valid_out, 0);
    chk("stray_rdy", bus.l1i_ready_out, 1);
    chk("stray_mreq", bus.mem_req_valid_out, 0);
    for (int i = 0; i < L1I_SETS; i++) mv[i] = 1'b0;
    last_line = '0; last_la = '0;
    // Valid bits were cleared and the stray data was not installed.
    issue(64'h5040, 0); serve(64'h5040, 0, 0, 1, r);
    issue(64'h3000, 0); serve(64'h3000, 0, 0, 0, r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
